fetch_unit: RTL and testbench

Program-counter and fetch sequencer for the 9-bit core; the consumer of the `jump_en` / `branch_en` decisions produced by the control decoder. Holds the PC and steps it each cycle. Resolves absolute jumps and PC-relative branches through a small loadable target table. Runs a start/run/halt state machine and reports completion and an execution cycle count to the test harness.

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch_unit control, target-table and status signal bundle
//
// Purpose: groups every non-clock, non-reset signal of fetch_unit.
// Ports (fields):
//   Start, jump_en, branch_en, halt, stall  - control inputs to the fetch unit
//   lut_idx                                 - target-table read index
//   lut_we, lut_waddr, lut_wdata            - target-table write port
//   prog_ctr, fetch_valid, done, cycle_count - fetch unit status outputs
// Modports: master drives the controls and observes status; slave is the fetch unit.
interface fetch_unit_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
);
    logic              Start;
    logic              jump_en;
    logic              branch_en;
    logic              halt;
    logic              stall;
    logic [LUT_AW-1:0] lut_idx;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   prog_ctr;
    logic              fetch_valid;
    logic              done;
    logic [15:0]       cycle_count;

    modport master (
        output Start, jump_en, branch_en, halt, stall, lut_idx,
               lut_we, lut_waddr, lut_wdata,
        input  prog_ctr, fetch_valid, done, cycle_count
    );

    modport slave (
        input  Start, jump_en, branch_en, halt, stall, lut_idx,
               lut_we, lut_waddr, lut_wdata,
        output prog_ctr, fetch_valid, done, cycle_count
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and fetch sequencer with jump/branch target table
//
// Purpose: holds the PC, steps it every RUN cycle, resolves absolute jumps and
// PC-relative branches through a loadable target table, and runs an
// IDLE/RUN/HALTED sequencer that reports done and a RUN cycle count.
// Ports:
//   Clk    - clock, all state updates on the rising edge
//   Reset  - synchronous, active-high reset
//   bus    - fetch_unit_if.slave: controls, target-table write port, status
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter int              LUT_AW     = 5,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int LUT_N = 1 << LUT_AW;

    state_t          state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic            done_r, done_next;
    logic [15:0]     count, count_next;
    logic [PC_W-1:0] lut [LUT_N];
    logic [PC_W-1:0] lut_rd;

    // Combinational read; a same-cycle write lands at the edge, so the read
    // sees the old entry.
    assign lut_rd = lut[bus.lut_idx];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            pc     <= START_ADDR;
            done_r <= 1'b0;
            count  <= 16'd0;
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            done_r <= done_next;
            count  <= count_next;
            if (bus.lut_we) begin
                lut[bus.lut_waddr] <= bus.lut_wdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        done_next  = done_r;
        count_next = count;
        case (state)
            RUN: begin
                // Every RUN cycle counts, stalled or halting included.
                if (count != 16'hFFFF) begin
                    count_next = count + 16'd1;
                end
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_next = HALTED;
                        done_next  = 1'b1;
                    end else if (bus.jump_en) begin
                        pc_next = lut_rd;
                    end else if (bus.branch_en) begin
                        // Entry is a two's-complement offset; modulo wrap is intended.
                        pc_next = pc + lut_rd;
                    end else begin
                        pc_next = pc + 1'b1;
                    end
                end
            end
            default: begin
                if (bus.Start) begin
                    state_next = RUN;
                    pc_next    = START_ADDR;
                    done_next  = 1'b0;
                    count_next = 16'd0;
                end
            end
        endcase
    end

    assign bus.prog_ctr    = pc;
    assign bus.fetch_valid = (state == RUN);
    assign bus.done        = done_r;
    assign bus.cycle_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit_if #(.PC_W(10), .LUT_AW(5)) bus ();

    fetch_unit #(.PC_W(10), .LUT_AW(5), .START_ADDR(10'd0)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int          at;
        logic [9:0]  pc;
        logic        fv;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: architectural view of the sequencer
    int m_state;   // 0 idle, 1 running, 2 halted
    int m_pc;
    int m_done;
    int m_cnt;
    int m_lut[32];

    function automatic void check(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endfunction

    task automatic model(input bit r, input bit st, input bit j, input bit b,
                         input bit h, input bit s, input int idx,
                         input bit we, input int wa, input int wd);
        int rd;
        if (r) begin
            m_state = 0; m_pc = 0; m_done = 0; m_cnt = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            rd = m_lut[idx];
            if (m_state != 1) begin
                if (st) begin
                    m_state = 1; m_pc = 0; m_done = 0; m_cnt = 0;
                end
            end else begin
                if (m_cnt < 65535) m_cnt++;
                if (!s) begin
                    if (h) begin
                        m_state = 2; m_done = 1;
                    end else if (j) begin
                        m_pc = rd;
                    end else if (b) begin
                        m_pc = (m_pc + rd) % 1024;
                    end else begin
                        m_pc = (m_pc + 1) % 1024;
                    end
                end
            end
            if (we) m_lut[wa] = wd;
        end
    endtask

    // One clock of stimulus; the expectation for the coming edge is queued.
    task automatic drive(input bit r, input bit st, input bit j, input bit b,
                         input bit h, input bit s, input int idx,
                         input bit we = 0, input int wa = 0, input int wd = 0);
        exp_t e;
        rst           = r;
        bus.Start     = st;
        bus.jump_en   = j;
        bus.branch_en = b;
        bus.halt      = h;
        bus.stall     = s;
        bus.lut_idx   = idx[4:0];
        bus.lut_we    = we;
        bus.lut_waddr = wa[4:0];
        bus.lut_wdata = wd[9:0];
        model(r, st, j, b, h, s, idx, we, wa, wd);
        e.at   = cyc + 1;
        e.pc   = m_pc[9:0];
        e.fv   = (m_state == 1);
        e.done = m_done[0];
        e.cnt  = m_cnt[15:0];
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs after each edge against queued expectations
    always @(posedge clk) begin
        #3;
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check("prog_ctr",    int'(bus.prog_ctr),    int'(e.pc));
            check("fetch_valid", int'(bus.fetch_valid), int'(e.fv));
            check("done",        int'(bus.done),        int'(e.done));
            check("cycle_count", int'(bus.cycle_count), int'(e.cnt));
        end
    end

    initial begin
        bus.Start = 0; bus.jump_en = 0; bus.branch_en = 0; bus.halt = 0;
        bus.stall = 0; bus.lut_idx = 0; bus.lut_we = 0; bus.lut_waddr = 0;
        bus.lut_wdata = 0;
        @(posedge clk);
        #1;
        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        plain(1);
        // Start, load table while stepping
        drive(0, 1, 0, 0, 0, 0, 0, 1, 3, 200);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 10'h3FC);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 50);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 1023);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 1020);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 6);
        // Jump, backward branch, jump beats branch, halt beats both
        drive(0, 0, 1, 0, 0, 0, 3);
        drive(0, 0, 0, 1, 0, 0, 7);
        drive(0, 0, 1, 1, 0, 0, 1);
        plain(2);
        drive(0, 1, 1, 1, 1, 0, 1);
        plain(2);
        // Restart, wrap at 1023, branch across the wrap
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 4);
        plain(2);
        drive(0, 0, 1, 0, 0, 0, 5);
        drive(0, 0, 0, 1, 0, 0, 6);
        // Start ignored in RUN; stall freezes but counts
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 1, 1, 3);
        drive(0, 0, 0, 0, 1, 0, 0);
        plain(2);
        // Same-cycle write/read of one entry returns the old value
        drive(0, 1, 0, 0, 0, 0, 0, 1, 8, 37);
        drive(0, 0, 1, 0, 0, 0, 9, 1, 9, 100);
        drive(0, 0, 1, 0, 0, 0, 9);
        drive(0, 0, 1, 0, 0, 0, 8);
        // Reset mid-RUN with Start, then table must be cleared
        drive(1, 1, 0, 0, 0, 0, 0);
        plain(1);
        drive(0, 1, 0, 0, 0, 0, 0);
        plain(2);
        drive(0, 0, 1, 0, 0, 0, 3);
        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023))
                                               : int'($urandom_range(0, 1023)));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #5;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
